// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative RV32M multiply/divide unit for the EX stage.
//
// Ports:
//   CLK     in   1  rising-edge clock
//   RESETN  in   1  asynchronous active-low reset
//   START   in   1  request, taken when not BUSY and ALUOP is 11..18
//   ALUOP   in   5  11 MUL, 12 MULH, 13 MULHSU, 14 MULHU,
//                   15 DIV, 16 DIVU, 17 REM, 18 REMU
//   DATA1   in  32  rs1 (multiplicand / dividend)
//   DATA2   in  32  rs2 (multiplier / divisor)
//   RESULT  out 32  registered result, held until the next completion
//   BUSY    out  1  operation in progress
//   DONE    out  1  one-cycle pulse, RESULT valid in the same cycle
//
// Build option MULDIV_FAST_MUL_EN: multiplies use a single-cycle 64-bit
// product in state MUL instead of the 32-cycle shift-add loop.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for START
// MUL     | unsigned multiply iterations on operand magnitudes
// DIV     | unsigned restoring-divide iterations on magnitudes
// SPECIAL | divide-by-zero / signed overflow, result already known
// FIX     | apply sign correction and select output half
// DONE    | RESULT valid, DONE high; a new START may be taken here
module muldiv_unit (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        START,
  input  logic [4:0]  ALUOP,
  input  logic [31:0] DATA1,
  input  logic [31:0] DATA2,
  output logic [31:0] RESULT,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic [2:0] {
    S_IDLE, S_MUL, S_DIV, S_SPECIAL, S_FIX, S_DONE
  } state_t;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  state_t      state_q, state_d;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q;
  logic        neg_q;
  logic [63:0] acc_q;
  logic [4:0]  cnt_q;

  logic        op_valid, accept, is_div_in, sgn1, sgn2;
  logic        div_zero, div_ovf, special_in;
  logic [2:0]  op_in;
  logic [31:0] mag1, mag2, special_val;

  // op_in[2] selects divide; within divides op_in[1] selects remainder.
  assign op_valid  = (ALUOP >= 5'd11) && (ALUOP <= 5'd18);
  assign op_in     = 3'(ALUOP - 5'd11);
  assign is_div_in = op_in[2];
  assign accept    = START && op_valid && (state_q == S_IDLE || state_q == S_DONE);

  assign sgn1 = DATA1[31] && (op_in == OP_MULH || op_in == OP_MULHSU ||
                              op_in == OP_DIV  || op_in == OP_REM);
  assign sgn2 = DATA2[31] && (op_in == OP_MULH || op_in == OP_DIV || op_in == OP_REM);
  assign mag1 = sgn1 ? -DATA1 : DATA1;
  assign mag2 = sgn2 ? -DATA2 : DATA2;

  assign div_zero    = is_div_in && (DATA2 == 32'd0);
  assign div_ovf     = (op_in == OP_DIV || op_in == OP_REM) &&
                       (DATA1 == 32'h8000_0000) && (DATA2 == 32'hFFFF_FFFF);
  assign special_in  = div_zero || div_ovf;
  assign special_val = div_zero ? (op_in[1] ? DATA1 : 32'hFFFF_FFFF)
                                : (op_in[1] ? 32'd0 : 32'h8000_0000);

  // Restoring divide step: partial remainder lives in acc_q[63:32], the
  // dividend shifts out of the top of acc_q[31:0] as quotient bits shift in.
  logic [32:0] div_shift;
  logic [33:0] div_trial;
  logic [31:0] div_rem_next;
  assign div_shift    = {acc_q[63:32], acc_q[31]};
  assign div_trial    = {1'b0, div_shift} - {2'b00, b_q};
  assign div_rem_next = div_trial[33] ? div_shift[31:0] : div_trial[31:0];

`ifndef MULDIV_FAST_MUL_EN
  // Shift-add step: multiplier sits in acc_q[31:0] and drains LSB first.
  logic [32:0] mul_sum;
  assign mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
`endif

  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix, fix_val;
  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo_fix  = neg_q ? -acc_q[31:0] : acc_q[31:0];
  assign rem_fix  = neg_q ? -acc_q[63:32] : acc_q[63:32];

  always_comb begin
    fix_val = prod_fix[63:32];
    case (op_q)
      OP_MUL:           fix_val = prod_fix[31:0];
      OP_DIV, OP_DIVU:  fix_val = quo_fix;
      OP_REM, OP_REMU:  fix_val = rem_fix;
      default:          fix_val = prod_fix[63:32];
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (special_in)     state_d = S_SPECIAL;
          else if (is_div_in) state_d = S_DIV;
          else                state_d = S_MUL;
        end else begin
          state_d = S_IDLE;
        end
      end
`ifdef MULDIV_FAST_MUL_EN
      S_MUL:     state_d = S_FIX;
`else
      S_MUL:     if (cnt_q == 5'd0) state_d = S_FIX;
`endif
      S_DIV:     if (cnt_q == 5'd0) state_d = S_FIX;
      S_SPECIAL: state_d = S_DONE;
      S_FIX:     state_d = S_DONE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= S_IDLE;
      op_q    <= OP_MUL;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      neg_q   <= 1'b0;
      acc_q   <= 64'd0;
      cnt_q   <= 5'd0;
      RESULT  <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= op_in;
        // A special case parks its final answer in a_q; no iteration follows.
        a_q   <= special_in ? special_val : mag1;
        b_q   <= mag2;
        neg_q <= (is_div_in && op_in[1]) ? sgn1 : (sgn1 ^ sgn2);
        acc_q <= {32'd0, is_div_in ? mag1 : mag2};
        cnt_q <= 5'd31;
      end else begin
        case (state_q)
`ifdef MULDIV_FAST_MUL_EN
          S_MUL: acc_q <= {32'd0, a_q} * {32'd0, b_q};
`else
          S_MUL: begin
            acc_q <= {mul_sum, acc_q[31:1]};
            cnt_q <= cnt_q - 5'd1;
          end
`endif
          S_DIV: begin
            acc_q <= {div_rem_next, acc_q[30:0], ~div_trial[33]};
            cnt_q <= cnt_q - 5'd1;
          end
          S_FIX:     RESULT <= fix_val;
          S_SPECIAL: RESULT <= a_q;
          default: ;
        endcase
      end
    end
  end

  assign BUSY = (state_q == S_MUL) || (state_q == S_DIV) ||
                (state_q == S_SPECIAL) || (state_q == S_FIX);
  assign DONE = (state_q == S_DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        CLK;
  logic        RESETN;
  logic        START;
  logic [4:0]  ALUOP;
  logic [31:0] DATA1, DATA2;
  logic [31:0] RESULT;
  logic        BUSY, DONE;

  int vectors;
  int miscompares;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_CYC = 3;
`else
  localparam int MUL_CYC = 34;
`endif
  localparam int DIV_CYC = 34;
  localparam int SPC_CYC = 2;

  localparam logic [4:0] A_ADD = 5'd1,  A_MUL = 5'd11, A_MULH = 5'd12, A_MULHSU = 5'd13;
  localparam logic [4:0] A_MULHU = 5'd14, A_DIV = 5'd15, A_DIVU = 5'd16, A_REM = 5'd17;
  localparam logic [4:0] A_REMU = 5'd18;

  muldiv_unit dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .START  (START),
    .ALUOP  (ALUOP),
    .DATA1  (DATA1),
    .DATA2  (DATA2),
    .RESULT (RESULT),
    .BUSY   (BUSY),
    .DONE   (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drives a request on the next accepting edge; returns at the negedge of cycle 1.
  task automatic launch(input logic [4:0] op, input logic [31:0] d1, input logic [31:0] d2);
    @(negedge CLK);
    START = 1'b1; ALUOP = op; DATA1 = d1; DATA2 = d2;
    @(negedge CLK);
    START = 1'b0; ALUOP = 5'd0; DATA1 = 32'hDEAD_BEEF; DATA2 = 32'h1234_5678;
  endtask

  // Starting at the negedge of cycle start_c, waits (bounded) for DONE.
  task automatic wait_done(input int start_c, output int cyc, output logic busy_ok,
                           output logic [31:0] res);
    cyc = 0; busy_ok = 1'b1; res = 32'h0BAD_0BAD;
    for (int c = start_c; c <= 45 && cyc == 0; c++) begin
      if (DONE) begin
        cyc = c; res = RESULT;
        if (BUSY) busy_ok = 1'b0;
      end else begin
        if (!BUSY) busy_ok = 1'b0;
        @(negedge CLK);
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] exp_res, input int exp_cyc);
    int cyc; logic bok; logic [31:0] res;
    launch(op, d1, d2);
    wait_done(1, cyc, bok, res);
    check({tag, " result"}, res, exp_res);
    check({tag, " done cycle"}, 32'(cyc), 32'(exp_cyc));
    check({tag, " busy window"}, {31'd0, bok}, 32'd1);
  endtask

  initial begin
    int cyc; logic bok; logic [31:0] res;
    int busy_cnt, done_cnt;
    vectors = 0; miscompares = 0;
    RESETN = 1'b0; START = 1'b0; ALUOP = 5'd0; DATA1 = 32'd0; DATA2 = 32'd0;
    repeat (3) @(negedge CLK);
    check("reset RESULT", RESULT, 32'd0);
    check("reset BUSY", {31'd0, BUSY}, 32'd0);
    check("reset DONE", {31'd0, DONE}, 32'd0);
    RESETN = 1'b1;

    run_op("MUL 7*-3",        A_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_CYC);
    run_op("MULH min*min",    A_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_CYC);
    run_op("MULHU max*max",   A_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_CYC);
    run_op("MULHSU -1*max",   A_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_CYC);
    run_op("DIV -7/2",        A_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, DIV_CYC);
    run_op("REM -7/2",        A_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, DIV_CYC);
    run_op("DIVU 100/7",      A_DIVU,   32'd100,       32'd7,         32'd14,        DIV_CYC);
    run_op("REMU 100/7",      A_REMU,   32'd100,       32'd7,         32'd2,         DIV_CYC);
    run_op("DIV 5/0",         A_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, SPC_CYC);
    run_op("DIV ovf",         A_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPC_CYC);
    run_op("REM ovf",         A_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         SPC_CYC);
    run_op("REMU 5/0",        A_REMU,   32'd5,         32'd0,         32'd5,         SPC_CYC);

    // Non-M opcode: nothing should happen and RESULT must hold.
    launch(A_ADD, 32'd1, 32'd2);
    busy_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (BUSY) busy_cnt++;
      if (DONE) done_cnt++;
      @(negedge CLK);
    end
    check("ADD busy cycles", 32'(busy_cnt), 32'd0);
    check("ADD done cycles", 32'(done_cnt), 32'd0);
    check("ADD result held", RESULT, 32'd5);

    // START during cycle 5 of a DIV is ignored.
    launch(A_DIV, 32'd100, 32'd7);
    repeat (4) @(negedge CLK);
    START = 1'b1; ALUOP = A_MUL; DATA1 = 32'd3; DATA2 = 32'd3;
    @(negedge CLK);
    START = 1'b0; ALUOP = 5'd0;
    wait_done(6, cyc, bok, res);
    check("busy START result", res, 32'd14);
    check("busy START done cycle", 32'(cyc), 32'(DIV_CYC));
    @(negedge CLK);
    check("busy START no extra op", {31'd0, BUSY}, 32'd0);

    // Back-to-back: second request presented in the DONE cycle.
    launch(A_DIVU, 32'd100, 32'd7);
    wait_done(1, cyc, bok, res);
    check("b2b first result", res, 32'd14);
    START = 1'b1; ALUOP = A_REMU; DATA1 = 32'd100; DATA2 = 32'd7;
    @(negedge CLK);
    START = 1'b0; ALUOP = 5'd0; DATA1 = 32'hDEAD_BEEF;
    check("b2b busy cycle 1", {31'd0, BUSY}, 32'd1);
    wait_done(1, cyc, bok, res);
    check("b2b second result", res, 32'd2);
    check("b2b second done cycle", 32'(cyc), 32'(DIV_CYC));

    // Reset during cycle 10 of a DIVU.
    launch(A_DIVU, 32'd100, 32'd7);
    repeat (9) @(negedge CLK);
    #1 RESETN = 1'b0;
    #1;
    check("abort RESULT", RESULT, 32'd0);
    check("abort BUSY", {31'd0, BUSY}, 32'd0);
    check("abort DONE", {31'd0, DONE}, 32'd0);
    @(negedge CLK);
    RESETN = 1'b1;
    busy_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (BUSY) busy_cnt++;
      if (DONE) done_cnt++;
      @(negedge CLK);
    end
    check("post-abort busy cycles", 32'(busy_cnt), 32'd0);
    check("post-abort done cycles", 32'(done_cnt), 32'd0);

    run_op("MULHU after abort", A_MULHU, 32'h0001_0000, 32'h0003_0000, 32'd3, MUL_CYC);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

- Iterative RV32M multiply/divide execution unit.
- Consumes the 5-bit ALUOP codes 11–18 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) issued by the instruction decoder, and returns a 32-bit result through a START/BUSY/DONE handshake.
- Sits in the EX stage beside the single-cycle ALU; the pipeline stalls while BUSY is high.

## Interface

Parameters:
- None; datapath fixed at 32 bits.

Ports (one clock; reset is asynchronous and active-low):
- CLK  in  1  rising-edge clock
- RESETN  in  1  asynchronous active-low reset
- START  in  1  request; sampled on a CLK edge when the unit is not BUSY
- ALUOP  in  5  operation code: 11 MUL, 12 MULH, 13 MULHSU, 14 MULHU, 15 DIV, 16 DIVU, 17 REM, 18 REMU
- DATA1  in  32  rs1 operand (multiplicand / dividend)
- DATA2  in  32  rs2 operand (multiplier / divisor)
- RESULT  out  32  registered result; held until the next accepted START
- BUSY  out  1  operation in progress
- DONE  out  1  one-cycle pulse; RESULT is valid in the same cycle

## Operation

- **Reset values:** RESULT=0, BUSY=0, DONE=0, state=IDLE.
- **Accepted START:** START=1, unit in IDLE or DONE, and ALUOP in 11..18.
  - On acceptance, ALUOP, DATA1, DATA2 and the sign flags are latched. Inputs may change afterwards.
  - START with any other ALUOP is ignored: no BUSY, no DONE.
- **States:**
  - IDLE → MUL or DIV on accept.
  - IDLE → SPECIAL on a divide special case.
  - MUL / DIV → FIX after 32 iterations.
  - FIX → DONE.
  - SPECIAL → DONE.
  - DONE → IDLE, or straight to a new op on START.
- **Signedness:**
  - Operands become magnitudes when signed: DATA1 for MULH, MULHSU, DIV, REM; DATA2 for MULH, DIV, REM.
  - Core is unsigned. FIX negates the output when required.
- **Multiply:**
  - Radix-2 shift-add, one bit per cycle, 64-bit accumulator.
  - MUL returns product[31:0]; MULH, MULHSU, MULHU return product[63:32].
  - Product is negated as 64 bits when the operand signs differ.
- **Divide:**
  - Restoring divide, one quotient bit per cycle, 33-bit partial remainder.
  - Quotient sign = XOR of operand signs; remainder sign = dividend sign.
- **Special cases** (detected at accept, no iteration):
  - Divisor 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return DATA1.
  - Signed overflow (DIV/REM, 0x80000000 / 0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- **START while BUSY:** ignored, with no effect on the operation in flight.
- **Reset mid-operation:** the operation aborts; all outputs and state return to reset values immediately. No DONE follows.

## Timing

- Cycle 1 is the cycle after the accepting edge.
- **Iterative ops:**
  - BUSY high in cycles 1–33 (32 iterations + FIX).
  - DONE=1 and RESULT valid in cycle 34.
  - BUSY=0 in the DONE cycle.
- **Special cases:** BUSY high in cycle 1; DONE in cycle 2.
- **Back-to-back:** a START sampled during the DONE cycle is accepted; BUSY rises in the next cycle. Throughput is one op per 34 cycles.
- **DONE:** exactly one cycle wide; never asserted without a preceding accepted START.
- **RESULT:** changes only on the DONE cycle (and on reset).

## Configuration

- **MULDIV_FAST_MUL_EN**
  - Defined: multiplies use a single-cycle 64-bit product computed in state MUL (one cycle), then FIX. DONE in cycle 3. Divides are unchanged.
  - Undefined: 32-cycle shift-add multiplier as above, DONE in cycle 34.
- All results are bit-identical in both builds.

## Test plan

- **MUL and cycle count:** MUL 7 × 0xFFFFFFFD → RESULT 0xFFFFFFEB; DONE exactly in cycle 34 (cycle 3 with MULDIV_FAST_MUL_EN); BUSY high cycles 1–33.
- **High-half multiplies:**
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- **Divide / remainder:**
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD.
  - REM 0xFFFFFFF9 / 2 → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14.
  - REMU 100 / 7 → 2.
- **Special cases:** each with DONE in cycle 2.
  - DIV 5 / 0 → 0xFFFFFFFF.
  - REMU 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF → 0.
- **Handshake:**
  - START with ALUOP=1 (ADD) → no BUSY, no DONE.
  - START during cycle 5 of a DIV → ignored; the original result is unchanged.
  - START in the DONE cycle → the second op completes 34 cycles later.
- **Reset mid-operation:** RESETN low in cycle 10 of a DIVU → RESULT, BUSY, DONE all 0 asynchronously. After release, no DONE until a new START.
